// File: rtl/alu_negate_serial.sv
// alu_negate_serial: bit-serial complement unit for the KGP-RISC ALU.
//
// Turns an operand into its one's complement (NOT), two's-complement negation
// (NEG), absolute value (ABS) or an unchanged copy (PASS). It handles one bit
// per clock, starting at the LSB, and uses a start/done handshake. The
// controller holds off while busy is high.
//
// Ports:
//   clk     system clock; all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   start   request; only looked at in IDLE
//   mode    00 NOT, 01 NEG, 10 ABS, 11 PASS; captured together with start
//   a       operand; captured together with start
//   busy    high while the unit is in RUN
//   done    one-cycle pulse; result/ovf are valid from this cycle on
//   result  computed value; held until the next start is accepted
//   ovf     overflow flag (negating the most negative value); held with result
//
// Timing: start is captured at edge E0. busy is high from E0 to E_WIDTH. done is
// high between E_WIDTH and E_WIDTH+1. The earliest next capture is E_WIDTH+2.

module alu_negate_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ModeNot  = 2'b00,
    ModeNeg  = 2'b01,
    ModeAbs  = 2'b10,
    ModePass = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  // inv_q: invert each bit. neg_q: the op is a true negation, so it can overflow.
  logic             inv_q, inv_d;
  logic             neg_q, neg_d;
  logic             sign_q, sign_d;

  logic             cur_bit;
  logic             out_bit;

  // The operand register shifts right, so the bit being worked on is always at bit 0.
  assign cur_bit = opnd_q[0];
  assign out_bit = inv_q ? (~cur_bit ^ carry_q) : cur_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    neg_d    = neg_q;
    sign_d   = sign_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          opnd_d   = a;
          sign_d   = a[WIDTH-1];
          cnt_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = StRun;
          unique case (mode_e'(mode))
            ModeNot: begin
              inv_d   = 1'b1;
              carry_d = 1'b0;
              neg_d   = 1'b0;
            end
            ModeNeg: begin
              inv_d   = 1'b1;
              carry_d = 1'b1;
              neg_d   = 1'b1;
            end
            // ABS works like NEG for a negative operand and like PASS otherwise.
            ModeAbs: begin
              inv_d   = a[WIDTH-1];
              carry_d = a[WIDTH-1];
              neg_d   = a[WIDTH-1];
            end
            ModePass: begin
              inv_d   = 1'b0;
              carry_d = 1'b0;
              neg_d   = 1'b0;
            end
            default: begin
              inv_d   = 1'b0;
              carry_d = 1'b0;
              neg_d   = 1'b0;
            end
          endcase
        end
      end

      StRun: begin
        opnd_d   = {1'b0, opnd_q[WIDTH-1:1]};
        result_d = {out_bit, result_q[WIDTH-1:1]};
        // The carry stays 0 for PASS and NOT. It can only die out, never start
        // again, so the carry out of the MSB is simply dropped.
        carry_d  = ~cur_bit & carry_q;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
          // out_bit is the MSB of the final result. It is only set when
          // 100...0 is negated.
          ovf_d   = neg_q & sign_q & out_bit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      neg_q    <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      neg_q    <= neg_d;
      sign_q   <= sign_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_negate_serial.sv
// Directed testbench for alu_negate_serial (WIDTH = 32).
module tb_alu_negate_serial;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_negate_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Run one operation and check latency, busy length, the done pulse and the results.
  // With scramble set, start/a/mode are changed during RUN. Those changes must
  // have no effect on the result.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [W-1:0] opa,
                        input logic [W-1:0] exp_res, input logic exp_ovf, input bit scramble);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = opa;
    @(posedge clk);  // E0: capture
    #1;
    check({tag, "_ovf_clr"}, W'(ovf), W'(1'b0));
    start    = 1'b0;
    cyc      = 0;
    busy_cnt = busy ? 1 : 0;
    seen     = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      if (scramble && cyc < 28) begin
        start = ~start;
        a     = $urandom;
        mode  = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, W'(cyc), W'(32));
    check({tag, "_busy_len"}, W'(busy_cnt), W'(32));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_ovf"}, W'(ovf), W'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, W'(done), W'(1'b0));
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int done_cyc[$];
    int c;
    bit prev_done;
    bit double_pulse;

    start = 1'b0;
    mode  = 2'b00;
    a     = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_result", result, '0);
    check("rst_ovf", W'(ovf), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b01;
    a     = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy_before", W'(busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("midrun_busy", W'(busy), W'(1'b0));
    check("midrun_done", W'(done), W'(1'b0));
    check("midrun_result", result, '0);
    check("midrun_ovf", W'(ovf), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) c++;
    end
    check("midrun_no_done", W'(c), W'(0));
    run_op("post_rst_neg5", 2'b01, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0);

    run_op("not", 2'b00, 32'h0F0F_00FF, 32'hF0F0_FF00, 1'b0, 1'b0);
    run_op("neg1", 2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("neg0", 2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_op("neg_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    // run_op checks that this next start clears ovf
    run_op("abs_neg10", 2'b10, 32'hFFFF_FFF6, 32'h0000_000A, 1'b0, 1'b0);
    run_op("abs_pos", 2'b10, 32'h0000_007B, 32'h0000_007B, 1'b0, 1'b0);
    run_op("abs_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    run_op("pass", 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op("scramble_neg", 2'b01, 32'h1234_5678, 32'hEDCB_A988, 1'b0, 1'b1);

    // Hold start high: one op every 34 cycles, and each done lasts one cycle
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b01;
    a     = 32'h0000_0003;
    @(posedge clk);
    c            = 0;
    prev_done    = 1'b0;
    double_pulse = 1'b0;
    repeat (110) begin
      @(posedge clk);
      #1;
      c++;
      if (done) begin
        done_cyc.push_back(c);
        if (prev_done) double_pulse = 1'b1;
        check("held_result", result, 32'hFFFF_FFFD);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("held_pulses", W'(done_cyc.size()), W'(3));
    check("held_double", W'(double_pulse), W'(1'b0));
    if (done_cyc.size() == 3) begin
      check("held_first", W'(done_cyc[0]), W'(32));
      check("held_gap1", W'(done_cyc[1] - done_cyc[0]), W'(34));
      check("held_gap2", W'(done_cyc[2] - done_cyc[1]), W'(34));
    end
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
